// File: rtl/ladybird_config_pkg.sv
// Shared ladybird configuration: peripheral offsets, payload types and helpers.
package ladybird_config;

   localparam int unsigned XLEN = 32;
   localparam int unsigned STRB_W = 4;

   localparam int unsigned TIMER_MTIME_LO    = 32'h00;
   localparam int unsigned TIMER_MTIME_HI    = 32'h04;
   localparam int unsigned TIMER_MTIMECMP_LO = 32'h08;
   localparam int unsigned TIMER_MTIMECMP_HI = 32'h0C;
   localparam int unsigned TIMER_CTRL        = 32'h10;
   localparam int unsigned TIMER_PRESCALE    = 32'h14;

   // enable is bit 0, irq_en is bit 1
   typedef struct packed {
      logic irq_en;
      logic enable;
   } timer_ctrl_t;

   typedef enum logic [2:0] {
      ACCESS_NONE,
      ACCESS_RAM,
      ACCESS_GPIO,
      ACCESS_UART,
      ACCESS_TIMER
   } access_t;

   typedef enum logic [1:0] {
      TIMER_IDLE,
      TIMER_WAIT,
      TIMER_RESP
   } timer_state_t;

   // Merge new_val into old_val on the byte lanes selected by strb.
   function automatic logic [XLEN-1:0] apply_wstrb(input logic [XLEN-1:0] old_val,
                                                   input logic [XLEN-1:0] new_val,
                                                   input logic [STRB_W-1:0] strb);
      logic [XLEN-1:0] res;
      res = old_val;
      for (int i = 0; i < int'(STRB_W); i++) begin
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/ladybird_bus_interface.sv
// Peripheral request/grant bus between the crossbar (primary) and a responder (secondary).
interface ladybird_bus_interface;
   logic        req;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        gnt;
   logic        rdgnt;
   logic [31:0] rdata;

   modport primary   (output req, addr, wstrb, wdata, input  gnt, rdgnt, rdata);
   modport secondary (input  req, addr, wstrb, wdata, output gnt, rdgnt, rdata);
endinterface

// File: rtl/ladybird_timer_counter.sv
// Prescaled 64-bit mtime counter; bus writes to either half override the tick.
module ladybird_timer_counter
   import ladybird_config::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] prescale,
   input  logic        prescale_wr,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic [63:0] mtime
);

   logic [15:0] pre_cnt;
   logic        tick_c;

   assign tick_c = enable && (pre_cnt >= prescale);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
      end else if (!enable || prescale_wr || tick_c) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 16'd1;
      end
   end

   // A write to either half drops that cycle's increment entirely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime <= '0;
      end else if (wr_lo || wr_hi) begin
         if (wr_lo) mtime[31:0]  <= apply_wstrb(mtime[31:0], wdata, wstrb);
         if (wr_hi) mtime[63:32] <= apply_wstrb(mtime[63:32], wdata, wstrb);
      end else if (tick_c) begin
         mtime <= mtime + 64'd1;
      end
   end

endmodule

// File: rtl/ladybird_timer.sv
// Memory-mapped machine timer: mtime/mtimecmp/ctrl/prescale behind a ladybird bus port.
module ladybird_timer
   import ladybird_config::*;
#(
   parameter int unsigned RD_LATENCY  = 1,
   parameter int unsigned OFFSET_BITS = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   ladybird_bus_interface.secondary       bus,
   output logic                           irq
);

   localparam int unsigned LAT_W = 4;

   timer_state_t   state_q, state_d;
   logic [LAT_W-1:0] lat_cnt_q;
   logic [63:0]    mtime;
   logic [63:0]    mtimecmp_q;
   timer_ctrl_t    ctrl_q;
   logic [15:0]    prescale_q;
   logic [31:0]    rdata_q;
   logic [31:0]    rd_val_c;
   logic [31:0]    off_c;
   logic           accept_c, store_c, load_c;
   logic           gnt_c, rdgnt_c;
   logic           unused_addr;

   assign accept_c = (state_q == TIMER_IDLE) && bus.req;
   assign store_c  = accept_c && (bus.wstrb != 4'b0000);
   assign load_c   = accept_c && (bus.wstrb == 4'b0000);
   assign off_c    = 32'(bus.addr[OFFSET_BITS-1:0]) & ~32'h3;
   assign unused_addr = ^{bus.addr[31:OFFSET_BITS], bus.addr[1:0]};

   ladybird_timer_counter u_counter (
      .clk         (clk),
      .rst         (rst),
      .enable      (ctrl_q.enable),
      .prescale    (prescale_q),
      .prescale_wr (store_c && (off_c == TIMER_PRESCALE)),
      .wr_lo       (store_c && (off_c == TIMER_MTIME_LO)),
      .wr_hi       (store_c && (off_c == TIMER_MTIME_HI)),
      .wstrb       (bus.wstrb),
      .wdata       (bus.wdata),
      .mtime       (mtime)
   );

   // Register read mux; unmapped offsets read zero.
   always_comb begin
      rd_val_c = '0;
      case (off_c)
         TIMER_MTIME_LO:    rd_val_c = mtime[31:0];
         TIMER_MTIME_HI:    rd_val_c = mtime[63:32];
         TIMER_MTIMECMP_LO: rd_val_c = mtimecmp_q[31:0];
         TIMER_MTIMECMP_HI: rd_val_c = mtimecmp_q[63:32];
         TIMER_CTRL:        rd_val_c = 32'(ctrl_q);
         TIMER_PRESCALE:    rd_val_c = 32'(prescale_q);
         default:           rd_val_c = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtimecmp_q <= '1;
         ctrl_q     <= '0;
         prescale_q <= '0;
      end else if (store_c) begin
         case (off_c)
            TIMER_MTIMECMP_LO: mtimecmp_q[31:0]  <= apply_wstrb(mtimecmp_q[31:0], bus.wdata, bus.wstrb);
            TIMER_MTIMECMP_HI: mtimecmp_q[63:32] <= apply_wstrb(mtimecmp_q[63:32], bus.wdata, bus.wstrb);
            TIMER_CTRL:        ctrl_q     <= timer_ctrl_t'(2'(apply_wstrb(32'(ctrl_q), bus.wdata, bus.wstrb)));
            TIMER_PRESCALE:    prescale_q <= 16'(apply_wstrb(32'(prescale_q), bus.wdata, bus.wstrb));
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq     <= 1'b0;
         rdata_q <= '0;
      end else begin
         irq <= ctrl_q.irq_en & (mtime >= mtimecmp_q);
         if (load_c) rdata_q <= rd_val_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_cnt_q <= '0;
      end else if (load_c) begin
         lat_cnt_q <= LAT_W'(RD_LATENCY - 1);
      end else if (state_q == TIMER_WAIT) begin
         lat_cnt_q <= lat_cnt_q - LAT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= TIMER_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         TIMER_IDLE: if (load_c) state_d = (RD_LATENCY == 1) ? TIMER_RESP : TIMER_WAIT;
         TIMER_WAIT: if (lat_cnt_q <= LAT_W'(1)) state_d = TIMER_RESP;
         TIMER_RESP: state_d = TIMER_IDLE;
         default:    state_d = TIMER_IDLE;
      endcase
   end

   // Handshake outputs decode state only.
   always_comb begin
      gnt_c   = 1'b0;
      rdgnt_c = 1'b0;
      case (state_q)
         TIMER_IDLE: gnt_c   = 1'b1;
         TIMER_RESP: rdgnt_c = 1'b1;
         default: ;
      endcase
   end

   assign bus.gnt   = gnt_c;
   assign bus.rdgnt = rdgnt_c;
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_ladybird_timer.sv
// Directed self-checking bench for ladybird_timer (RD_LATENCY=3).
module tb_ladybird_timer;

   logic clk = 1'b0;
   logic rst;
   logic irq;
   int   vectors = 0;
   int   miscompares = 0;

   ladybird_bus_interface bus ();

   ladybird_timer #(.RD_LATENCY(3), .OFFSET_BITS(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .irq (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      bus.req = 1'b1; bus.addr = a; bus.wdata = d; bus.wstrb = s;
      @(posedge clk);
      #1;
      bus.req = 1'b0; bus.wstrb = 4'b0000;
   endtask

   task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic        seen;
      logic [31:0] d;
      seen = 1'b0;
      d    = '0;
      @(negedge clk);
      bus.req = 1'b1; bus.addr = a; bus.wstrb = 4'b0000;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.rdgnt === 1'b1) begin
            seen = 1'b1;
            d    = bus.rdata;
         end
      end
      check({tag, "_rdgnt_seen"}, 64'(seen), 64'd1);
      check(tag, 64'(d), 64'(exp));
   endtask

   initial begin
      rst = 1'b1;
      bus.req = 1'b0; bus.addr = '0; bus.wstrb = '0; bus.wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_gnt", 64'(bus.gnt), 64'd1);
      check("rst_rdgnt", 64'(bus.rdgnt), 64'd0);
      check("rst_irq", 64'(irq), 64'd0);
      check("rst_rdata", 64'(bus.rdata), 64'd0);
      rst = 1'b0;

      bus_read("rst_cmp_hi", 32'h0C, 32'hFFFF_FFFF);
      bus_read("rst_mtime_lo", 32'h00, 32'h0);

      // Load latency with RD_LATENCY=3; prescale keeps only bits [15:0]
      bus_write(32'h14, 32'hABCD_0007, 4'b1111);
      @(negedge clk);
      bus.req = 1'b1; bus.addr = 32'h14; bus.wstrb = 4'b0000;
      #1;
      check("lat_c0_gnt", 64'(bus.gnt), 64'd1);
      check("lat_c0_rdgnt", 64'(bus.rdgnt), 64'd0);
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check($sformatf("lat_c%0d_gnt", c), 64'(bus.gnt), 64'd0);
         check($sformatf("lat_c%0d_rdgnt", c), 64'(bus.rdgnt), (c == 3) ? 64'd1 : 64'd0);
      end
      check("lat_c3_rdata", 64'(bus.rdata), 64'h7);
      @(negedge clk);
      check("lat_c4_gnt", 64'(bus.gnt), 64'd1);
      check("lat_c4_rdgnt", 64'(bus.rdgnt), 64'd0);
      check("lat_c4_rdata_hold", 64'(bus.rdata), 64'h7);

      // Byte strobes, unused bits, unmapped offsets, ignored upper address bits
      bus_write(32'h08, 32'hAABB_CCDD, 4'b0101);
      bus_read("strb_cmp_lo", 32'h08, 32'hFFBB_FFDD);
      bus_write(32'h10, 32'hFFFF_FFFC, 4'b1111);
      bus_read("ctrl_unused_bits", 32'h10, 32'h0);
      bus_write(32'h18, 32'h1234_5678, 4'b1111);
      bus_read("unmapped_18", 32'h18, 32'h0);
      bus_read("upper_addr_ignored", 32'h4000_0014, 32'h7);

      // Carry LO->HI over two ticks
      bus_write(32'h14, 32'h0, 4'b1111);
      bus_write(32'h00, 32'hFFFF_FFFE, 4'b1111);
      bus_write(32'h04, 32'h0, 4'b1111);
      bus_write(32'h10, 32'h1, 4'b1111);
      @(posedge clk);
      bus_write(32'h10, 32'h0, 4'b1111);
      bus_read("carry_hi", 32'h04, 32'h1);
      bus_read("carry_lo", 32'h00, 32'h0);

      // 64-bit wrap with a single tick
      bus_write(32'h00, 32'hFFFF_FFFF, 4'b1111);
      bus_write(32'h04, 32'hFFFF_FFFF, 4'b1111);
      bus_write(32'h10, 32'h1, 4'b1111);
      bus_write(32'h10, 32'h0, 4'b1111);
      bus_read("wrap_lo", 32'h00, 32'h0);
      bus_read("wrap_hi", 32'h04, 32'h0);

      // Store on a tick cycle: written value held, increment dropped
      bus_write(32'h00, 32'h0, 4'b1111);
      bus_write(32'h10, 32'h1, 4'b1111);
      bus_write(32'h00, 32'h100, 4'b1111);
      bus_write(32'h10, 32'h0, 4'b1111);
      bus_read("collide_lo", 32'h00, 32'h101);
      bus_read("collide_hi", 32'h04, 32'h0);

      // Interrupt: cmp=10, prescale=1 -> mtime hits 10 twenty cycles after enable
      bus_write(32'h00, 32'h0, 4'b1111);
      bus_write(32'h04, 32'h0, 4'b1111);
      bus_write(32'h0C, 32'h0, 4'b1111);
      bus_write(32'h08, 32'd10, 4'b1111);
      bus_write(32'h14, 32'h1, 4'b1111);
      bus_write(32'h10, 32'h3, 4'b1111);
      repeat (21) @(negedge clk);
      check("irq_before_match", 64'(irq), 64'd0);
      @(negedge clk);
      check("irq_after_match", 64'(irq), 64'd1);
      bus_write(32'h08, 32'd100, 4'b1111);
      @(negedge clk);
      check("irq_write_cycle", 64'(irq), 64'd1);
      @(negedge clk);
      check("irq_dropped", 64'(irq), 64'd0);
      bus_write(32'h08, 32'd0, 4'b1111);

      // Reset asserted mid-cycle while a load waits
      @(negedge clk);
      bus.req = 1'b1; bus.addr = 32'h0C; bus.wstrb = 4'b0000;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      check("abort_irq_before", 64'(irq), 64'd1);
      @(negedge clk);
      check("abort_wait_gnt", 64'(bus.gnt), 64'd0);
      #2;
      rst = 1'b1;
      #1;
      check("abort_gnt", 64'(bus.gnt), 64'd1);
      check("abort_rdgnt", 64'(bus.rdgnt), 64'd0);
      check("abort_irq", 64'(irq), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("abort_no_rdgnt_%0d", i), 64'(bus.rdgnt), 64'd0);
      end
      bus_read("post_rst_cmp_hi", 32'h0C, 32'hFFFF_FFFF);
      bus_read("post_rst_ctrl", 32'h10, 32'h0);
      bus_read("post_rst_mtime_lo", 32'h00, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
